// File: rtl/pr_request_queue.sv
// PR request queue: the core enqueues 32-bit request words; the host claims and
// retires the head entry over a minimal AXI-lite slave and the core gets a done pulse.
module pr_request_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REQ_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pr_req_valid,
  input  logic [REQ_W-1:0] pr_req_data,
  output logic             pr_req_ready,
  output logic             pr_done,
  output logic             pr_done_error,
  input  logic [1:0]       s_axi_awaddr,
  input  logic             s_axi_awvalid,
  output logic             s_axi_awready,
  input  logic [REQ_W-1:0] s_axi_wdata,
  input  logic             s_axi_wvalid,
  output logic             s_axi_wready,
  output logic             s_axi_bvalid,
  input  logic             s_axi_bready,
  input  logic [1:0]       s_axi_araddr,
  input  logic             s_axi_arvalid,
  output logic             s_axi_arready,
  output logic [REQ_W-1:0] s_axi_rdata,
  output logic             s_axi_rvalid,
  input  logic             s_axi_rready,
  output logic             pr_request_pending
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_BUSY    = 2'd2;

  localparam logic [1:0] WA_START = 2'd0;
  localparam logic [1:0] WA_DONE  = 2'd1;
  localparam logic [1:0] WA_FLUSH = 2'd2;

  localparam logic [1:0] RA_HEAD   = 2'd0;
  localparam logic [1:0] RA_STATUS = 2'd1;
  localparam logic [1:0] RA_LAST   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [REQ_W-1:0] mem_d [DEPTH];

  logic             pr_req_ready_q, pr_req_ready_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic             done_err_q, done_err_d;
  logic             last_err_q, last_err_d;
  logic             bvalid_q, bvalid_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [REQ_W-1:0] rdata_q, rdata_d;

  logic             wr_fire_c;
  logic             ar_fire_c;
  logic             push_c;
  logic             wr_start_c;
  logic             wr_done_c;
  logic             wr_flush_c;
  logic             empty_c;
  logic             full_c;
  logic             busy_c;
  logic [31:0]      count_w_c;
  logic [2:0]       cnt_sat_c;
  logic [REQ_W-1:0] head_c;
  logic             wdata_unused;

  assign wdata_unused = ^s_axi_wdata[REQ_W-1:1];

  // Handshake qualification and write decode
  always_comb begin
    wr_fire_c  = s_axi_awvalid && s_axi_wvalid && !bvalid_q;
    ar_fire_c  = s_axi_arvalid && arready_q;
    push_c     = pr_req_valid && pr_req_ready_q;
    wr_start_c = wr_fire_c && (s_axi_awaddr == WA_START) && (state_q == ST_PENDING);
    wr_done_c  = wr_fire_c && (s_axi_awaddr == WA_DONE) && (state_q == ST_BUSY);
    wr_flush_c = wr_fire_c && (s_axi_awaddr == WA_FLUSH);
  end

  // Queue flags from the registered count, never from pointer compare
  always_comb begin
    empty_c   = (count_q == '0);
    full_c    = (count_q == CNT_W'(DEPTH));
    busy_c    = (state_q == ST_BUSY);
    count_w_c = 32'(count_q);
    cnt_sat_c = (count_w_c > 32'd7) ? 3'd7 : count_w_c[2:0];
    head_c    = empty_c ? '0 : mem_q[rd_ptr_q];
  end

  // FIFO storage, pointers and count; FLUSH overrides a same-cycle push
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = pr_req_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      count_d         = count_q + CNT_W'(1);
    end
    if (wr_done_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_d - CNT_W'(1);
    end
    if (wr_flush_c) begin
      if (busy_c) begin
        wr_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = CNT_W'(1);
      end else begin
        wr_ptr_d = rd_ptr_q;
        count_d  = '0;
      end
    end
  end

  // Request sequencing FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (count_d != '0) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (wr_start_c)          state_d = ST_BUSY;
        else if (count_d == '0)  state_d = ST_IDLE;
      end
      ST_BUSY: begin
        if (wr_done_c) state_d = (count_d != '0) ? ST_PENDING : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Core-facing and AXI response next values
  always_comb begin
    pr_req_ready_d = (count_d != CNT_W'(DEPTH));
    pending_d      = (state_d == ST_PENDING);
    done_d         = wr_done_c;
    done_err_d     = wr_done_c & s_axi_wdata[0];
    last_err_d     = wr_done_c ? s_axi_wdata[0] : last_err_q;

    bvalid_d = bvalid_q;
    if (wr_fire_c)         bvalid_d = 1'b1;
    else if (s_axi_bready) bvalid_d = 1'b0;

    rvalid_d = rvalid_q;
    if (ar_fire_c)         rvalid_d = 1'b1;
    else if (s_axi_rready) rvalid_d = 1'b0;
    arready_d = !rvalid_d;

    rdata_d = rdata_q;
    if (ar_fire_c) begin
      case (s_axi_araddr)
        RA_HEAD:   rdata_d = head_c;
        RA_STATUS: rdata_d = REQ_W'({busy_c, full_c, empty_c, 2'b00, cnt_sat_c});
        RA_LAST:   rdata_d = REQ_W'(last_err_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      pr_req_ready_q <= 1'b1;
      pending_q      <= 1'b0;
      done_q         <= 1'b0;
      done_err_q     <= 1'b0;
      last_err_q     <= 1'b0;
      bvalid_q       <= 1'b0;
      arready_q      <= 1'b0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      mem_q          <= mem_d;
      pr_req_ready_q <= pr_req_ready_d;
      pending_q      <= pending_d;
      done_q         <= done_d;
      done_err_q     <= done_err_d;
      last_err_q     <= last_err_d;
      bvalid_q       <= bvalid_d;
      arready_q      <= arready_d;
      rvalid_q       <= rvalid_d;
      rdata_q        <= rdata_d;
    end
  end

  // Write address/data accept together, gated by an outstanding response
  assign s_axi_awready      = wr_fire_c;
  assign s_axi_wready       = wr_fire_c;
  assign s_axi_bvalid       = bvalid_q;
  assign s_axi_arready      = arready_q;
  assign s_axi_rvalid       = rvalid_q;
  assign s_axi_rdata        = rdata_q;
  assign pr_req_ready       = pr_req_ready_q;
  assign pr_done            = done_q;
  assign pr_done_error      = done_err_q;
  assign pr_request_pending = pending_q;

endmodule

// File: doc/pr_request_queue.md
Name: pr_request_queue

Overview:
- Sequences partial-reconfiguration (PR) requests from the Taiga core to a host-side PR manager.
- The core enqueues 32-bit request words into a small FIFO. The host reads the head entry over a minimal AXI-lite slave, claims it (START), and retires it (DONE).
- The core receives a completion pulse with an error flag.
- Sits beside the core in the Xilinx wrapper and drives the top-level s_axi_* ports and pr_request_pending.

Parameters:
- DEPTH, 4, number of queued requests; power of 2, >= 2.
- REQ_W, 32, request word width; fixed at 32 to match the AXI-lite data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- pr_req_valid  in  1  core request strobe
- pr_req_data  in  32  request word: region id, bitstream id
- pr_req_ready  out  1  queue can accept a request
- pr_done  out  1  one-cycle pulse: head request retired
- pr_done_error  out  1  error flag, valid with pr_done
- s_axi_awaddr  in  2  write word index
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  2  read word index
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- pr_request_pending  out  1  head entry waiting to be claimed

Behaviour:
- Reset (rst=0, async):
  - FIFO empty, state IDLE, last_status=0.
  - All outputs 0 except pr_req_ready=1.
- Enqueue:
  - pr_req_ready = !full, from registered count.
  - A push occurs on pr_req_valid && pr_req_ready.
  - When full, a push is refused even if a DONE pop occurs the same cycle.
  - count and pending update the cycle after the push.
- State machine:
  - IDLE (empty) -> PENDING when count becomes non-zero.
  - PENDING -> BUSY on START write.
  - BUSY -> PENDING or IDLE on DONE write: pop head; pr_done=1 next cycle; pr_done_error=wdata[0]; last_status={31'b0, wdata[0]}.
  - pr_request_pending = (state==PENDING), registered.
- Write map (s_axi_awaddr):
  - 0 = START: ignored unless PENDING.
  - 1 = DONE: ignored unless BUSY; no pr_done pulse when ignored.
  - 2 = FLUSH: drops all entries except an in-progress head. Count becomes 1 if BUSY, else 0; state goes to IDLE if not BUSY.
  - 3 = no effect.
- Read map (s_axi_araddr):
  - 0 = head request word, or 0 if empty.
  - 1 = status {24'b0, busy[7], full[6], empty[5], 2'b0, count[2:0]}; count saturates in 3 bits, DEPTH<=4 fits.
  - 2 = last_status.
  - 3 = 0.
- AXI write handshake:
  - awready and wready are asserted together for one cycle only when awvalid && wvalid && !bvalid.
  - The write takes effect on that cycle.
  - bvalid rises the next cycle and holds until bready.
  - Address and data arriving separately wait; no buffering.
- AXI read handshake:
  - arready=1 when !rvalid.
  - rdata is captured at acceptance; rvalid is held until rready.
  - rdata holds stable while rvalid=1.
- FIFO wrap-around:
  - Pointers wrap modulo DEPTH.
  - full and empty derive from count, not pointer compare.
- Simultaneous events:
  - Push and DONE pop in one cycle: count unchanged.
  - Push and FLUSH in one cycle: FLUSH wins; the pushed word is dropped, but pr_req_ready had been honoured.
  - The core must tolerate this; documented as a lost request.
- Reset mid-transaction:
  - Abandons the queue and any open AXI beat; no pr_done is emitted.

Test Plan:
- Push 0xA1, 0xB2 -> cycle+1: pending=1; read addr1 = 0x02; read addr0 = 0x000000A1.
- Write START, then DONE with wdata=1 -> pr_done pulse for 1 cycle with pr_done_error=1; read addr2 = 1; head = 0xB2; pending=1.
- Push DEPTH=4 words -> pr_req_ready=0; a 5th push with concurrent DONE is refused; count=3 after.
- START, push 2 more, then FLUSH -> count=1, busy=1. DONE -> count=0, state IDLE, pending=0.
- DONE while PENDING, START while IDLE -> no state change, no pr_done, bvalid still returned.
- awvalid 3 cycles before wvalid, then bready held low 5 cycles -> single write effect; bvalid held; no second awready until bready.
